// File: rtl/pe_group_sched_pkg.sv
// Shared constants, widths and state encoding for the PE group layer scheduler.
package pe_group_sched_pkg;

  localparam int unsigned DimW   = 6;
  localparam int unsigned LayerW = 4;
  localparam int unsigned CntW   = 12;
  localparam int unsigned PE_LAT = 3;

  localparam logic [2:0] PROC_IDLE  = 3'd0;
  localparam logic [2:0] PROC_START = 3'd1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StPrime,
    StRun,
    StDrain,
    StFlush
  } state_e;

endpackage

// File: rtl/win_counter.sv
// Raster-order window position counter: col runs fastest and wraps at cols-1 into the next row.
module win_counter
  import pe_group_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            advance,
  input  logic [DimW-1:0] rows,
  input  logic [DimW-1:0] cols,
  output logic [DimW-1:0] row,
  output logic [DimW-1:0] col,
  output logic            last
);

  logic [DimW-1:0] row_q, row_d, col_q, col_d;
  logic            col_end, row_end;

  always_comb begin
    col_end = (col_q == cols - 6'd1);
    row_end = (row_q == rows - 6'd1);
    last    = col_end && row_end;
    row_d   = row_q;
    col_d   = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 6'd1;
      end else begin
        col_d = col_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/pe_group_sched.sv
// Layer-pass scheduler: loads weights, streams ifmap windows to the PE group, drains it,
// and writes back output-map results until the whole map has been stored.
module pe_group_sched
  import pe_group_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LayerW-1:0] layer,
  input  logic [DimW-1:0]   out_cols,
  input  logic [DimW-1:0]   out_rows,
  input  logic              wb_en,
  output logic [2:0]        process,
  output logic              finish_flag,
  output logic              w_rd_en,
  output logic [LayerW-1:0] w_addr,
  output logic              if_rd_en,
  output logic [DimW-1:0]   if_row,
  output logic [DimW-1:0]   if_col,
  output logic              ofm_we,
  output logic [CntW-1:0]   ofm_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] DrainLast = 2'(PE_LAT - 1);

  state_e            state_q, state_d;
  logic [LayerW-1:0] layer_q;
  logic [DimW-1:0]   cols_q, rows_q;
  logic [CntW-1:0]   wb_cnt_q, total;
  logic [1:0]        drain_q, drain_d;
  logic              win_done_q, win_done_d;
  logic              err_q;
  logic              accept, bad_start, win_adv, win_last;

  win_counter u_win_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .advance (win_adv),
    .rows    (rows_q),
    .cols    (cols_q),
    .row     (if_row),
    .col     (if_col),
    .last    (win_last)
  );

  assign total    = CntW'(rows_q) * CntW'(cols_q);
  assign busy     = (state_q != StIdle);
  assign ofm_we   = wb_en && busy && (wb_cnt_q < total);
  assign ofm_addr = wb_cnt_q;
  assign err      = err_q;

  always_comb begin
    state_d     = state_q;
    drain_d     = (state_q == StDrain) ? drain_q + 2'd1 : '0;
    win_done_d  = win_done_q;
    win_adv     = 1'b0;
    accept      = 1'b0;
    bad_start   = 1'b0;
    process     = PROC_IDLE;
    finish_flag = 1'b0;
    w_rd_en     = 1'b0;
    w_addr      = '0;
    if_rd_en    = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // abort in the same cycle drops the start entirely
        if (start && !abort) begin
          if (out_cols != '0 && out_rows != '0) begin
            accept     = 1'b1;
            win_done_d = 1'b0;
            state_d    = StLoadW;
          end else begin
            bad_start = 1'b1;
          end
        end
      end
      StLoadW: begin
        w_rd_en = 1'b1;
        w_addr  = layer_q;
        state_d = StPrime;
      end
      StPrime: begin
        if_rd_en   = 1'b1;
        win_adv    = 1'b1;
        win_done_d = win_last;
        state_d    = StRun;
      end
      StRun: begin
        process  = PROC_START;
        if_rd_en = !win_done_q;
        win_adv  = !win_done_q;
        if (win_done_q || win_last) state_d = StDrain;
      end
      StDrain: begin
        finish_flag = 1'b1;
        if (drain_q == DrainLast) state_d = StFlush;
      end
      StFlush: begin
        if (wb_cnt_q == total) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      layer_q    <= '0;
      cols_q     <= '0;
      rows_q     <= '0;
      wb_cnt_q   <= '0;
      drain_q    <= '0;
      win_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      win_done_q <= win_done_d;
      if (accept) begin
        layer_q  <= layer;
        cols_q   <= out_cols;
        rows_q   <= out_rows;
        wb_cnt_q <= '0;
        err_q    <= 1'b0;
      end else begin
        if (ofm_we)    wb_cnt_q <= wb_cnt_q + 12'd1;
        if (bad_start) err_q    <= 1'b1;
      end
    end
  end

endmodule
